video_line_prefetcher: RTL and testbench

- Video-clock-domain stage between the framebuffer memory read port and the compositor's per-frame pixel input.
- Prefetches one 320-pixel source line (80 words of 32 bits) into a ping-pong line buffer ahead of display.
- Serves one 8-bit pixel per clock, pixel-doubled to 640x480 from pixel_x_pos/pixel_y_pos.
- Decouples the pixel path from memory arbitration latency.

---
 rtl/video_line_prefetcher_pkg.sv | 30 +++
 rtl/video_line_buffer.sv | 42 ++++
 rtl/video_line_prefetcher.sv | 158 +++++++++++++++
 tb/tb_video_line_prefetcher.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/video_line_prefetcher_pkg.sv
// Shared constants and types for the video line prefetcher.
//   Display geometry: 640x480 active, 525 total lines.
//   Source geometry:  320x240, pixel-doubled in both directions.
//   Memory layout:    80 words per source line, two frames back to back.
//   Fetch FSM state encoding and the source-line offset helper.
package video_line_prefetcher_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam int SRC_WIDTH      = 320;
  localparam int SRC_HEIGHT     = 240;
  localparam int WORDS_PER_LINE = SRC_WIDTH / 4;

  localparam logic [6:0]  LAST_WORD   = 7'(WORDS_PER_LINE - 1);
  localparam logic [15:0] FRAME_WORDS = 16'(WORDS_PER_LINE * SRC_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // src * 80 as shift-add; 239*80 + 19200 + 79 = 38399 stays within 16 bits.
  function automatic logic [15:0] line_offset(input logic [7:0] src);
    return ({8'd0, src} << 6) + ({8'd0, src} << 4);
  endfunction

endpackage

// File: rtl/video_line_buffer.sv
// Dual-bank ping-pong line buffer, 2 banks x 80 words x 32 bits.
//   clk_i, rst_i         : pixel clock, async active-high reset (read reg only)
//   wr_en_i/wr_bank_i/wr_index_i/wr_data_i : word write into the back bank
//   rd_en_i/rd_bank_i/rd_index_i/rd_sel_i  : byte read from the front bank
//   rd_byte_o            : registered byte, forced to 0 when rd_en_i is low
module video_line_buffer
  import video_line_prefetcher_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic        wr_bank_i,
  input  logic [6:0]  wr_index_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_en_i,
  input  logic        rd_bank_i,
  input  logic [6:0]  rd_index_i,
  input  logic [1:0]  rd_sel_i,
  output logic [7:0]  rd_byte_o
);

  // Storage carries no reset: contents are meaningless until a fetch fills them.
  logic [31:0] mem_q [2][WORDS_PER_LINE];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_bank_i][wr_index_i] <= wr_data_i;
  end

  assign rd_word = mem_q[rd_bank_i][rd_index_i];

  // Little-endian byte lanes: byte 0 is bits 7:0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rd_byte_q <= 8'd0;
    else if (rd_en_i) rd_byte_q <= rd_word[{rd_sel_i, 3'b000} +: 8];
    else              rd_byte_q <= 8'd0;
  end

  assign rd_byte_o = rd_byte_q;

endmodule

// File: rtl/video_line_prefetcher.sv
// Video line prefetcher: fetches one 320-pixel source line (80 words) into
// the back bank of a ping-pong buffer during blanking and serves
// pixel-doubled 640x480 bytes from the front bank.
//   clock, reset        : pixel clock, async active-high reset
//   frame_select        : frame to fetch, sampled on the line-0 fetch strobe
//   line_strobe/next_line : start-of-hblank pulse and the upcoming line
//   pixel_x_pos/pixel_y_pos : display coordinate, pixel_data 1 cycle later
//   fb_read_enable/fb_read_address/fb_read_data : framebuffer word port
//   fetch_busy          : fetch FSM not idle
//   fetch_overrun       : sticky, a start or swap hit a running fetch
module video_line_prefetcher
  import video_line_prefetcher_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_select,
  input  logic        line_strobe,
  input  logic [9:0]  next_line,
  input  logic [9:0]  pixel_x_pos,
  input  logic [9:0]  pixel_y_pos,
  output logic        fb_read_enable,
  output logic [15:0] fb_read_address,
  input  logic [31:0] fb_read_data,
  output logic [7:0]  pixel_data,
  output logic        fetch_busy,
  output logic        fetch_overrun
);

  fetch_state_e state_q, state_d;

  logic        front_q;
  logic [6:0]  idx_q;
  logic [2:0]  drain_q;
  logic [15:0] frame_base_q, frame_base_d;
  logic [15:0] line_base_q, line_base_d;
  logic        overrun_q;

  // Request pipeline: stage 0 is this cycle's request, stage READ_LATENCY
  // lines up with fb_read_data for that request.
  logic [READ_LATENCY-1:0]      vld_pipe_q;
  logic [READ_LATENCY:0]        vld_pipe;
  logic [READ_LATENCY-1:0][6:0] idx_pipe_q;
  logic [READ_LATENCY:0][6:0]   idx_pipe;

  logic       is_frame, is_swap, start_fetch, busy, overrun_evt;
  logic [8:0] src_nxt;
  logic       wr_en;

  logic       active;
  logic [8:0] src_x;
  logic       unused_x_lsb;

  // ---------------------------------------------------------------- decode
  assign src_nxt     = next_line[9:1] + 9'd1;
  assign is_frame    = line_strobe && (next_line == V_TOTAL - 10'd1);
  assign is_swap     = line_strobe && (next_line < V_ACTIVE) && !next_line[0];
  assign start_fetch = is_frame || (is_swap && (src_nxt < 9'(SRC_HEIGHT)));
  assign busy        = (state_q != ST_IDLE);
  assign overrun_evt = busy && (start_fetch || is_swap);

  assign frame_base_d = frame_select ? FRAME_WORDS : 16'd0;
  // The frame-start fetch uses the base latched on the same strobe.
  assign line_base_d  = is_frame ? frame_base_d
                                 : frame_base_q + line_offset(src_nxt[7:0]);

  // ------------------------------------------------------------- fetch FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_fetch) begin
      state_d = ST_ISSUE;
    end else if (is_swap && busy) begin
      // Swap with no follow-up fetch: the running fetch is abandoned.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ISSUE: if (idx_q == LAST_WORD) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_q == 3'(READ_LATENCY - 1)) state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fb_read_enable  = (state_q == ST_ISSUE);
    fb_read_address = line_base_q + {9'd0, idx_q};
    fetch_busy      = busy;
    fetch_overrun   = overrun_q;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      front_q      <= 1'b0;
      idx_q        <= 7'd0;
      drain_q      <= 3'd0;
      frame_base_q <= 16'd0;
      line_base_q  <= 16'd0;
      overrun_q    <= 1'b0;
    end else begin
      if (is_frame)    frame_base_q <= frame_base_d;
      if (is_swap)     front_q      <= ~front_q;
      if (overrun_evt) overrun_q    <= 1'b1;

      if (start_fetch) begin
        idx_q       <= 7'd0;
        line_base_q <= line_base_d;
      end else if (state_q == ST_ISSUE) begin
        idx_q <= (idx_q == LAST_WORD) ? 7'd0 : idx_q + 7'd1;
      end

      drain_q <= (state_q == ST_DRAIN) ? drain_q + 3'd1 : 3'd0;
    end
  end

  assign vld_pipe = {vld_pipe_q, fb_read_enable};
  assign idx_pipe = {idx_pipe_q, idx_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      // On overrun every in-flight return is dropped, including the one
      // landing this cycle (see wr_en).
      vld_pipe_q <= overrun_evt ? '0 : vld_pipe[READ_LATENCY-1:0];
      idx_pipe_q <= idx_pipe[READ_LATENCY-1:0];
    end
  end

  assign wr_en = vld_pipe[READ_LATENCY] && !overrun_evt;

  // ------------------------------------------------------------ pixel path
  assign active       = (pixel_x_pos < H_ACTIVE) && (pixel_y_pos < V_ACTIVE);
  assign src_x        = pixel_x_pos[9:1];
  assign unused_x_lsb = pixel_x_pos[0];

  video_line_buffer u_buf (
    .clk_i      (clock),
    .rst_i      (reset),
    .wr_en_i    (wr_en),
    .wr_bank_i  (~front_q),
    .wr_index_i (idx_pipe[READ_LATENCY]),
    .wr_data_i  (fb_read_data),
    .rd_en_i    (active),
    .rd_bank_i  (front_q),
    .rd_index_i (active ? src_x[8:2] : 7'd0),
    .rd_sel_i   (src_x[1:0]),
    .rd_byte_o  (pixel_data)
  );

endmodule

// File: tb/tb_video_line_prefetcher.sv
// Directed bench: two prefetchers (read latency 1 and 3) share stimulus,
// each fed by its own framebuffer model.
module tb_video_line_prefetcher;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_select = 1'b0;
  logic        line_strobe = 1'b0;
  logic [9:0]  next_line = 10'd0;
  logic [9:0]  px = 10'd0;
  logic [9:0]  py = 10'd0;

  logic        en1, en3, busy1, busy3, ovr1, ovr3;
  logic [15:0] addr1, addr3;
  logic [31:0] rd1, rd3, d3a, d3b;
  logic [7:0]  pix1, pix3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Word at address a holds bytes {4a+3, 4a+2, 4a+1, 4a} mod 256.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [7:0] b;
    b = {a[5:0], 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(posedge clock) begin
    rd1 <= mem_word(addr1);
    d3a <= mem_word(addr3);
    d3b <= d3a;
    rd3 <= d3b;
  end

  video_line_prefetcher #(.READ_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .frame_select(frame_select),
    .line_strobe(line_strobe), .next_line(next_line),
    .pixel_x_pos(px), .pixel_y_pos(py),
    .fb_read_enable(en1), .fb_read_address(addr1), .fb_read_data(rd1),
    .pixel_data(pix1), .fetch_busy(busy1), .fetch_overrun(ovr1)
  );

  video_line_prefetcher #(.READ_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .frame_select(frame_select),
    .line_strobe(line_strobe), .next_line(next_line),
    .pixel_x_pos(px), .pixel_y_pos(py),
    .fb_read_enable(en3), .fb_read_address(addr3), .fb_read_data(rd3),
    .pixel_data(pix3), .fetch_busy(busy3), .fetch_overrun(ovr3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [9:0] ln, input logic fs);
    next_line    = ln;
    frame_select = fs;
    line_strobe  = 1'b1;
    tick();
    line_strobe  = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic [7:0] e1, input logic [7:0] e3);
    px = x;
    py = y;
    tick();
    chk({tag, "/L1"}, 32'(pix1), 32'(e1));
    chk({tag, "/L3"}, 32'(pix3), 32'(e3));
  endtask

  // Called right after the start strobe: 80 consecutive requests from base,
  // busy for 80+latency cycles.
  task automatic check_fetch(input string tag, input logic [15:0] base);
    int b1 = 0;
    int b3 = 0;
    for (int c = 0; c < 100; c++) begin
      chk({tag, "_en1"}, 32'(en1), 32'(c < 80));
      chk({tag, "_en3"}, 32'(en3), 32'(c < 80));
      if (c < 80) begin
        chk({tag, "_addr1"}, 32'(addr1), 32'(base) + 32'(c));
        chk({tag, "_addr3"}, 32'(addr3), 32'(base) + 32'(c));
      end
      b1 += int'(busy1);
      b3 += int'(busy3);
      tick();
    end
    chk({tag, "_busy_cycles1"}, 32'(b1), 32'd81);
    chk({tag, "_busy_cycles3"}, 32'(b3), 32'd83);
  endtask

  initial begin
    logic [7:0] e;

    // Reset state
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_en1",   32'(en1),   32'd0);
    chk("rst_addr1", 32'(addr1), 32'd0);
    chk("rst_pix1",  32'(pix1),  32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ovr1",  32'(ovr1),  32'd0);
    chk("rst_en3",   32'(en3),   32'd0);
    chk("rst_addr3", 32'(addr3), 32'd0);
    chk("rst_pix3",  32'(pix3),  32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_ovr3",  32'(ovr3),  32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a fetch, on issue index 40
    px = 10'd2;
    py = 10'd0;
    strobe(10'd524, 1'b0);
    repeat (40) tick();
    chk("mid_addr1", 32'(addr1), 32'd40);
    chk("mid_en1",   32'(en1),   32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_en1",   32'(en1),   32'd0);
    chk("midrst_busy1", 32'(busy1), 32'd0);
    chk("midrst_pix1",  32'(pix1),  32'd0);
    chk("midrst_addr1", 32'(addr1), 32'd0);
    chk("midrst_en3",   32'(en3),   32'd0);
    chk("midrst_busy3", 32'(busy3), 32'd0);
    chk("midrst_pix3",  32'(pix3),  32'd0);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postrst_en1", 32'(en1), 32'd0);
      chk("postrst_en3", 32'(en3), 32'd0);
    end

    // Frame start from frame 1, then swap and fetch source line 1;
    // frame_select is ignored on the non-frame strobe.
    strobe(10'd524, 1'b1);
    check_fetch("frame_l0", 16'd19200);
    strobe(10'd0, 1'b0);
    chk("swap0_busy1", 32'(busy1), 32'd1);
    check_fetch("line1", 16'd19280);

    // Pixel mapping on row 0 from front bank (source line 0)
    for (int x = 0; x <= 640; x++) begin
      e = (x < 640) ? 8'(x >> 1) : 8'd0;
      pix("scan_y0", 10'(x), 10'd0, e, e);
    end
    pix("y1_x0",   10'd0,   10'd1,   8'h00, 8'h00);
    pix("y1_x1",   10'd1,   10'd1,   8'h00, 8'h00);
    pix("y1_x2",   10'd2,   10'd1,   8'h01, 8'h01);
    pix("y1_x639", 10'd639, 10'd1,   8'h3F, 8'h3F);
    pix("y1_x640", 10'd640, 10'd1,   8'h00, 8'h00);
    pix("y480_x2", 10'd2,   10'd480, 8'h00, 8'h00);

    // Odd line: nothing happens
    strobe(10'd1, 1'b0);
    chk("odd_busy1", 32'(busy1), 32'd0);
    chk("odd_busy3", 32'(busy3), 32'd0);
    pix("odd_noswap", 10'd2, 10'd0, 8'h01, 8'h01);

    // Line 478: swap to source line 1, no fetch of line 240
    strobe(10'd478, 1'b0);
    chk("l478_busy1", 32'(busy1), 32'd0);
    chk("l478_busy3", 32'(busy3), 32'd0);
    pix("l478_x2", 10'd2, 10'd0, 8'h41, 8'h41);
    pix("l478_x0", 10'd0, 10'd0, 8'h40, 8'h40);

    // Line 500: outside the active area, no action
    strobe(10'd500, 1'b0);
    chk("l500_busy1", 32'(busy1), 32'd0);
    chk("l500_busy3", 32'(busy3), 32'd0);
    pix("l500_x2", 10'd2, 10'd0, 8'h41, 8'h41);

    // Overrun: second line-2 strobe eleven cycles into the first fetch
    strobe(10'd2, 1'b0);
    chk("ovr_pre1",   32'(ovr1),  32'd0);
    chk("ovr_pre3",   32'(ovr3),  32'd0);
    chk("ovr_start1", 32'(addr1), 32'd19360);
    repeat (10) tick();
    chk("ovr_idx10", 32'(addr1), 32'd19370);
    strobe(10'd2, 1'b0);
    chk("ovr_set1",     32'(ovr1),  32'd1);
    chk("ovr_set3",     32'(ovr3),  32'd1);
    chk("ovr_restart1", 32'(addr1), 32'd19360);
    chk("ovr_restart3", 32'(addr3), 32'd19360);
    chk("ovr_en1",      32'(en1),   32'd1);
    repeat (100) tick();
    chk("ovr_sticky1", 32'(ovr1),  32'd1);
    chk("ovr_sticky3", 32'(ovr3),  32'd1);
    chk("ovr_idle1",   32'(busy1), 32'd0);
    chk("ovr_idle3",   32'(busy3), 32'd0);
    // Front bank now: leading words from line 2, the rest still line 1;
    // the word returning on the overrun cycle was dropped.
    pix("ovr_w6",  10'd48, 10'd0, 8'h98, 8'h98);
    pix("ovr_w7",  10'd56, 10'd0, 8'h9C, 8'h5C);
    pix("ovr_w8",  10'd64, 10'd0, 8'hA0, 8'h60);
    pix("ovr_w9",  10'd72, 10'd0, 8'h64, 8'h64);
    pix("ovr_w10", 10'd80, 10'd0, 8'h68, 8'h68);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
